// File: rtl/palette_ram_if.sv
// -----------------------------------------------------------------------------
// palette_ram_if
//   Bus bundle between a palette RAM and its users (CPU side and render side).
//
//   Signals (directions as seen from the palette RAM, i.e. the slave modport):
//     clr_req      in   single-cycle soft-clear request
//     cpu_rden     in   CPU read enable
//     cpu_wren     in   CPU write enable
//     cpu_addr     in   CPU address [AW-1:0]
//     cpu_wdata    in   CPU write data [DATA_W-1:0]
//     cpu_rdata    out  registered CPU read data
//     cpu_rvalid   out  cpu_rdata updated this cycle
//     render_rden  in   per-port render read enable [NUM_RPORTS-1:0]
//     render_addr  in   packed render addresses, port 0 in the LSBs
//     greyscale    in   mask render output to the greyscale column
//     render_data  out  packed registered render data, port 0 in the LSBs
//     busy         out  clear sequence in progress
//
//   The parameters must match those of the palette_ram instance bound to it.
// -----------------------------------------------------------------------------
interface palette_ram_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned NUM_RPORTS = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                         clr_req;
    logic                         cpu_rden;
    logic                         cpu_wren;
    logic [AW-1:0]                cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         cpu_rvalid;
    logic [NUM_RPORTS-1:0]        render_rden;
    logic [NUM_RPORTS*AW-1:0]     render_addr;
    logic                         greyscale;
    logic [NUM_RPORTS*DATA_W-1:0] render_data;
    logic                         busy;

    // Requester side: CPU plus render pipeline.
    modport master (
        output clr_req, cpu_rden, cpu_wren, cpu_addr, cpu_wdata,
        output render_rden, render_addr, greyscale,
        input  cpu_rdata, cpu_rvalid, render_data, busy
    );

    // Palette RAM side.
    modport slave (
        input  clr_req, cpu_rden, cpu_wren, cpu_addr, cpu_wdata,
        input  render_rden, render_addr, greyscale,
        output cpu_rdata, cpu_rvalid, render_data, busy
    );
endinterface : palette_ram_if

// File: rtl/palette_ram.sv
// -----------------------------------------------------------------------------
// palette_ram
//   Small colour-palette memory with one CPU read/write port and NUM_RPORTS
//   independent render read ports. All reads are registered (one cycle
//   latency). A single write port is shared between the CPU and the built-in
//   clear sequencer, which fills every entry with INIT_VAL after reset or on a
//   clr_req pulse. Reads that hit the address being written in the same cycle
//   return the new value (write-first).
//
//   Backdrop mirroring (MIRROR_EN=1, DEPTH=32 only): addresses 0x10/14/18/1C
//   alias 0x00/04/08/0C for both CPU and render accesses.
//
//   Ports:
//     clk    in   sole clock, rising edge
//     reset  in   synchronous, active-high reset
//     bus    slave modport of palette_ram_if (CPU, render and status signals)
// -----------------------------------------------------------------------------
module palette_ram #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       DEPTH      = 32,
    parameter int unsigned       NUM_RPORTS = 2,
    parameter bit                MIRROR_EN  = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL   = DATA_W'(8'h0F)
) (
    input  logic         clk,
    input  logic         reset,
    palette_ram_if.slave bus
);

    localparam int unsigned       AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]     LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [DATA_W-1:0] GREY_MASK = DATA_W'(8'h30);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // -------------------------------------------------------------------------
    // Address mirroring. The address is widened by one bit so that bit 4 can be
    // referenced even for DEPTH=16; with MIRROR_EN=0 the address passes through.
    // -------------------------------------------------------------------------
    function automatic logic [AW-1:0] f_mirror(input logic [AW-1:0] addr);
        logic [AW:0] ext;
        ext = {1'b0, addr};
        if (MIRROR_EN && ext[4] && (ext[1:0] == 2'b00)) begin
            ext[4] = 1'b0;
        end
        return ext[AW-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                       r_state;
    logic [AW-1:0]                r_clr_idx;
    logic                         r_busy;
    logic [DATA_W-1:0]            r_mem [DEPTH];
    logic [DATA_W-1:0]            r_cpu_rdata;
    logic                         r_cpu_rvalid;
    logic [NUM_RPORTS*DATA_W-1:0] r_render_data;

    // Shared write port
    logic                         w_we;
    logic [AW-1:0]                w_waddr;
    logic [DATA_W-1:0]            w_wdata;

    // Read paths
    logic [AW-1:0]                w_cpu_raddr;
    logic [DATA_W-1:0]            w_cpu_word;
    logic                         w_cpu_take;
    logic [AW-1:0]                w_rnd_addr [NUM_RPORTS];
    logic [DATA_W-1:0]            w_rnd_word [NUM_RPORTS];
    logic [DATA_W-1:0]            w_rnd_val  [NUM_RPORTS];

    // -------------------------------------------------------------------------
    // Clear / idle controller. busy is registered alongside the state so it
    // drops exactly one cycle after the last entry is written.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + AW'(1);
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // clr_req is only looked at here, so pulses during a clear
                    // pass are dropped.
                    if (bus.clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Write port arbitration: the clear sequencer owns the port during CLEAR,
    // the CPU owns it in IDLE. Nothing is written while reset is held.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = bus.cpu_wdata;
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                w_wdata = INIT_VAL;
            end else if (bus.cpu_wren) begin
                w_we    = 1'b1;
                w_waddr = f_mirror(bus.cpu_addr);
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are defined solely by
    // the clear sequence, which keeps it mappable to plain RAM/register files.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // CPU read path (write-first bypass, never masked)
    // -------------------------------------------------------------------------
    always_comb begin
        w_cpu_raddr = f_mirror(bus.cpu_addr);
        w_cpu_take  = (r_state == ST_IDLE) && bus.cpu_rden;
        if (w_we && (w_waddr == w_cpu_raddr)) begin
            w_cpu_word = w_wdata;
        end else begin
            w_cpu_word = r_mem[w_cpu_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_take;
            if (w_cpu_take) begin
                r_cpu_rdata <= w_cpu_word;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Render read paths. During CLEAR every port sees INIT_VAL, since the array
    // is only partially cleared. The greyscale mask is applied on the way in,
    // using the greyscale level of the request cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            w_rnd_addr[p] = f_mirror(bus.render_addr[p*AW +: AW]);
            if (r_state == ST_CLEAR) begin
                w_rnd_word[p] = INIT_VAL;
            end else if (w_we && (w_waddr == w_rnd_addr[p])) begin
                w_rnd_word[p] = w_wdata;
            end else begin
                w_rnd_word[p] = r_mem[w_rnd_addr[p]];
            end
            w_rnd_val[p] = bus.greyscale ? (w_rnd_word[p] & GREY_MASK) : w_rnd_word[p];
        end
    end

    // Each lane updates only when its own enable is high and holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_render_data <= '0;
        end else begin
            for (int p = 0; p < NUM_RPORTS; p++) begin
                if (bus.render_rden[p]) begin
                    r_render_data[p*DATA_W +: DATA_W] <= w_rnd_val[p];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.cpu_rvalid  = r_cpu_rvalid;
    assign bus.render_data = r_render_data;
    assign bus.busy        = r_busy;

endmodule : palette_ram

// File: tb/tb_palette_ram.sv
// -----------------------------------------------------------------------------
// tb_palette_ram
//   Directed bench for palette_ram with default parameters (8-bit entries,
//   32 deep, two render ports, mirroring on, INIT_VAL 0x0F). Inputs change
//   1 time unit after a rising edge; outputs are sampled at the same point,
//   i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_palette_ram;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned NUM_RPORTS = 2;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n_busy;

    palette_ram_if #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .NUM_RPORTS (NUM_RPORTS)
    ) bus ();

    palette_ram #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .NUM_RPORTS (NUM_RPORTS),
        .MIRROR_EN  (1'b1),
        .INIT_VAL   (8'h0F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int p);
        return bus.render_data[p*DATA_W +: DATA_W];
    endfunction

    task automatic idle_inputs();
        bus.clr_req     = 1'b0;
        bus.cpu_rden    = 1'b0;
        bus.cpu_wren    = 1'b0;
        bus.render_rden = '0;
        bus.greyscale   = 1'b0;
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
        bus.cpu_wren  = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        tick();
        bus.cpu_wren  = 1'b0;
    endtask

    // One read-request cycle on CPU and/or render ports.
    task automatic issue(input bit crd, input logic [4:0] ca, input logic [1:0] ren,
                         input logic [4:0] a0, input logic [4:0] a1, input bit grey);
        bus.cpu_rden    = crd;
        bus.cpu_addr    = ca;
        bus.render_rden = ren;
        bus.render_addr = {a1, a0};
        bus.greyscale   = grey;
        tick();
        idle_inputs();
    endtask

    // Counts samples with busy=1, starting from the current sample. At sample
    // poke_at it tries a CPU write of 0x11 to 0x02, a CPU read, a clr_req and
    // render reads of 0x05/0x06, all of which a clearing RAM must ignore or
    // answer with INIT_VAL.
    task automatic run_clear(input int poke_at, output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            idle_inputs();
            if (n == poke_at) begin
                bus.clr_req     = 1'b1;
                bus.cpu_wren    = 1'b1;
                bus.cpu_rden    = 1'b1;
                bus.cpu_addr    = 5'h02;
                bus.cpu_wdata   = 8'h11;
                bus.render_rden = 2'b11;
                bus.render_addr = {5'h06, 5'h05};
            end
            n++;
            tick();
            if (n == poke_at + 1) begin
                check("clear_rvalid", bus.cpu_rvalid, 1'b0);
                check("clear_lane0",  lane(0), 8'h0F);
                check("clear_lane1",  lane(1), 8'h0F);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.render_addr = '0;
        idle_inputs();

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_busy",   bus.busy, 1'b1);
        check("rst_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_rdata",  bus.cpu_rdata, 8'h00);
        check("rst_render", bus.render_data, 16'h0000);

        // ---------------- initial clear: 32 busy cycles ----------------
        reset = 1'b0;
        run_clear(-1, n_busy);
        check("init_busy_cycles", n_busy, 32);
        check("init_busy_low", bus.busy, 1'b0);

        issue(1'b0, 5'h00, 2'b11, 5'h03, 5'h1F, 1'b0);
        check("post_clr_lane0", lane(0), 8'h0F);
        check("post_clr_lane1", lane(1), 8'h0F);
        check("post_clr_norvalid", bus.cpu_rvalid, 1'b0);

        // ---------------- mirrored write / read ----------------
        cpu_wr(5'h14, 8'h21);
        issue(1'b1, 5'h04, 2'b10, 5'h00, 5'h14, 1'b0);
        check("mir_cpu_rdata",  bus.cpu_rdata, 8'h21);
        check("mir_cpu_rvalid", bus.cpu_rvalid, 1'b1);
        check("mir_lane1",      lane(1), 8'h21);
        check("mir_lane0_hold", lane(0), 8'h0F);
        tick();
        check("rvalid_pulse",   bus.cpu_rvalid, 1'b0);
        check("rdata_hold",     bus.cpu_rdata, 8'h21);
        check("lane1_hold",     lane(1), 8'h21);

        // ---------------- write-first bypass ----------------
        bus.cpu_wren  = 1'b1;
        bus.cpu_wdata = 8'h2A;
        issue(1'b1, 5'h05, 2'b01, 5'h05, 5'h00, 1'b0);
        bus.cpu_wren  = 1'b0;
        check("byp_lane0", lane(0), 8'h2A);
        check("byp_cpu",   bus.cpu_rdata, 8'h2A);

        // ---------------- mirror boundaries ----------------
        cpu_wr(5'h15, 8'h33);   // bit4 set but low bits 01: not mirrored
        cpu_wr(5'h0C, 8'h17);
        issue(1'b1, 5'h05, 2'b11, 5'h1C, 5'h15, 1'b0);
        check("mir_1c_lane0", lane(0), 8'h17);
        check("nomir_15_lane1", lane(1), 8'h33);
        check("nomir_05_cpu", bus.cpu_rdata, 8'h2A);

        // ---------------- greyscale ----------------
        cpu_wr(5'h06, 8'h3C);
        issue(1'b1, 5'h06, 2'b11, 5'h06, 5'h06, 1'b1);
        check("grey_lane0", lane(0), 8'h30);
        check("grey_lane1", lane(1), 8'h30);
        check("grey_cpu",   bus.cpu_rdata, 8'h3C);
        issue(1'b0, 5'h00, 2'b11, 5'h05, 5'h15, 1'b1);
        check("grey_2a_lane0", lane(0), 8'h20);
        check("grey_33_lane1", lane(1), 8'h30);

        // ---------------- soft clear via clr_req ----------------
        cpu_wr(5'h1F, 8'h2D);
        issue(1'b0, 5'h00, 2'b01, 5'h1F, 5'h00, 1'b0);
        check("pre_clr_1f", lane(0), 8'h2D);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("clr_busy_next", bus.busy, 1'b1);
        run_clear(5, n_busy);
        check("clr_busy_cycles", n_busy, 32);
        issue(1'b1, 5'h1F, 2'b11, 5'h1F, 5'h04, 1'b0);
        check("clr_cpu_1f",   bus.cpu_rdata, 8'h0F);
        check("clr_lane0_1f", lane(0), 8'h0F);
        check("clr_lane1_04", lane(1), 8'h0F);

        // ---------------- reset mid-clear restarts the pass ----------------
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (10) tick();
        check("mid_busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        check("mid_rst_busy",   bus.busy, 1'b1);
        check("mid_rst_render", bus.render_data, 16'h0000);
        check("mid_rst_rdata",  bus.cpu_rdata, 8'h00);
        tick();
        reset = 1'b0;
        run_clear(5, n_busy);
        check("mid_busy_cycles", n_busy, 32);
        issue(1'b1, 5'h02, 2'b11, 5'h02, 5'h06, 1'b0);
        check("mid_cpu_02",   bus.cpu_rdata, 8'h0F);
        check("mid_lane0_02", lane(0), 8'h0F);
        check("mid_lane1_06", lane(1), 8'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_palette_ram
